// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI mode-0 responder.
//   SPI_WIDTH    default word length, shared with the spi_master side of the link
//   spi_state_e  responder FSM encoding (IDLE=0, ACTIVE=1)
//   pin_sync_t   synchronised pin level plus single-cycle rise/fall pulses
package spi_slave_pkg;

  localparam int SPI_WIDTH = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } pin_sync_t;

endpackage

// File: rtl/spi_slave_if.sv
// Pin and fabric bundle for spi_slave.
//   Pins:   ss (active-low select), sck (idle low), mosi -> responder; miso <- responder
//   RX:     rx_data/rx_strobe/rx_overrun <- responder; rx_accept -> responder
//   TX:     tx_request/tx_underrun <- responder; tx_data/tx_strobe -> responder
// Modport 'slave' is the responder's view; 'master' is the external controller plus fabric.
interface spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);
  logic             ss;
  logic             sck;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] rx_data;
  logic             rx_strobe;
  logic             rx_accept;
  logic             rx_overrun;
  logic             tx_request;
  logic [WIDTH-1:0] tx_data;
  logic             tx_strobe;
  logic             tx_underrun;

  modport slave (
    input  ss, sck, mosi, rx_accept, tx_data, tx_strobe,
    output miso, rx_data, rx_strobe, rx_overrun, tx_request, tx_underrun
  );

  modport master (
    output ss, sck, mosi, rx_accept, tx_data, tx_strobe,
    input  miso, rx_data, rx_strobe, rx_overrun, tx_request, tx_underrun
  );
endinterface

// File: rtl/spi_slave_pin_sync.sv
// Multi-flop synchroniser with edge detection for one asynchronous SPI pin.
//   clk_i   system clock (mclk)
//   rst_ni  asynchronous active-low reset
//   pin_i   asynchronous pin
//   sync_o  synchronised level, plus rise/fall pulses one cycle wide
// Edges compare the last synchroniser stage against one further register,
// so a pulse is visible STAGES cycles after the pin is first sampled.
module spi_slave_pin_sync
  import spi_slave_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0   // idle level of the pin, avoids a fake edge after reset
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      pin_i,
  output pin_sync_t sync_o
);

  logic [STAGES-1:0] chain_q;
  logic              last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= {STAGES{RESET_VAL}};
      last_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], pin_i};
      last_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o.level = chain_q[STAGES-1];
  assign sync_o.rise  = chain_q[STAGES-1] & ~last_q;
  assign sync_o.fall  = ~chain_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, oversampling the pins in the mclk domain.
//   mclk_i    system clock, at least 4x the sck frequency
//   reset_ni  asynchronous active-low reset
//   bus       spi_slave_if.slave: ss/sck/mosi/miso pins, rx strobe/accept handshake,
//             tx request/strobe handshake, rx_overrun and tx_underrun pulses
// MOSI is captured on synchronised sck rises; MISO advances on sck falls.
// A word boundary (WIDTH-th rise) delivers the received word and loads the next
// transmit word from the holding register (zero plus an underrun pulse if empty).
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int   WIDTH       = SPI_WIDTH,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic        mclk_i,
  input  logic        reset_ni,
  spi_slave_if.slave  bus
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------------
  pin_sync_t ss_s, sck_s, mosi_s;

  spi_slave_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk_i (mclk_i), .rst_ni (reset_ni), .pin_i (bus.ss),   .sync_o (ss_s)
  );
  spi_slave_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk_i (mclk_i), .rst_ni (reset_ni), .pin_i (bus.sck),  .sync_o (sck_s)
  );
  spi_slave_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i (mclk_i), .rst_ni (reset_ni), .pin_i (bus.mosi), .sync_o (mosi_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  spi_state_e       state_q,      state_d;
  logic [CNT_W-1:0] bitcnt_q,     bitcnt_d;
  logic [WIDTH-1:0] shift_rx_q,   shift_rx_d;
  logic [WIDTH-1:0] shift_tx_q,   shift_tx_d;
  logic [WIDTH-1:0] hold_q,       hold_d;
  logic             hold_full_q,  hold_full_d;
  logic [WIDTH-1:0] rx_data_q,    rx_data_d;
  logic             rx_strobe_q,  rx_strobe_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             miso_q,       miso_d;
  logic             boundary_q,   boundary_d;  // next sck fall must not shift

  logic             word_done;
  logic             load_tx;
  logic [WIDTH-1:0] rx_word;
  logic [WIDTH-1:0] next_tx;

  assign rx_word   = {shift_rx_q[WIDTH-2:0], mosi_s.level};
  assign next_tx   = hold_full_q ? hold_q : '0;
  // ss_rise takes priority over a coincident sck rise: no bit is captured.
  assign word_done = (state_q == ST_ACTIVE) && !ss_s.rise && sck_s.rise && (bitcnt_q == LAST);
  assign load_tx   = ((state_q == ST_IDLE) && ss_s.fall) || word_done;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (ss_s.fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (ss_s.rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets its hold value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    bitcnt_d      = bitcnt_q;
    shift_rx_d    = shift_rx_q;
    shift_tx_d    = shift_tx_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_strobe_d   = rx_strobe_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    miso_d        = miso_q;
    boundary_d    = boundary_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ss_s.fall) begin
          bitcnt_d   = '0;
          shift_rx_d = '0;
          boundary_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (ss_s.rise) begin
          // Abandon the frame: partial rx bits and unsent tx bits are dropped.
          bitcnt_d   = '0;
          shift_rx_d = '0;
          shift_tx_d = '0;
          miso_d     = IDLE_MISO;
          boundary_d = 1'b0;
        end else if (sck_s.rise) begin
          shift_rx_d = rx_word;
          if (bitcnt_q == LAST) begin
            bitcnt_d   = '0;
            boundary_d = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end else if (sck_s.fall) begin
          // The fall right after a boundary already has the new MSB on miso.
          if (boundary_q) begin
            boundary_d = 1'b0;
          end else begin
            shift_tx_d = shift_tx_q << 1;
            miso_d     = shift_tx_q[WIDTH-2];
          end
        end
      end
      default: ;
    endcase

    if (load_tx) begin
      shift_tx_d    = next_tx;
      miso_d        = next_tx[WIDTH-1];
      tx_underrun_d = ~hold_full_q;
      hold_full_d   = 1'b0;
    end

    // Placed after the load so a coincident strobe refills the holding register
    // while the boundary takes its old contents.
    if (bus.tx_strobe) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    if (word_done && (!rx_strobe_q || bus.rx_accept)) begin
      rx_data_d   = rx_word;
      rx_strobe_d = 1'b1;
    end else begin
      if (word_done)     rx_overrun_d = 1'b1;
      if (bus.rx_accept) rx_strobe_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      shift_rx_q    <= '0;
      shift_tx_q    <= '0;
      // NOTE: the data-only registers are reset as well; they are a handful of
      // flops rather than a RAM, and rx_data must read zero straight out of reset.
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_strobe_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= IDLE_MISO;
      boundary_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shift_rx_q    <= shift_rx_d;
      shift_tx_q    <= shift_tx_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_strobe_q   <= rx_strobe_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
      boundary_q    <= boundary_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.miso        = miso_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_strobe   = rx_strobe_q;
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_request  = ~hold_full_q;
  assign bus.tx_underrun = tx_underrun_q;

  // Synchroniser outputs and the bit shifted out of shift_rx that nothing needs.
  logic unused_bits;
  assign unused_bits = ^{ss_s.level, sck_s.level, mosi_s.rise, mosi_s.fall, shift_rx_q[WIDTH-1]};

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: table-driven single-word transfers with a
// scoreboard for both directions, then hand-written back-to-back, overrun,
// partial-frame and reset-mid-transfer sequences.
module tb_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 4;          // sck half period in mclk cycles (sck = mclk/8)
  localparam int TMO  = 400;        // cycle budget for any wait on the DUT

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if #(.WIDTH(16)) bus ();

  spi_slave #(.WIDTH(16), .SYNC_STAGES(SYNC), .IDLE_MISO(1'b0)) dut (
    .mclk_i   (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  int tests  = 0;
  int failed = 0;
  int ovr_cnt = 0;
  int udr_cnt = 0;
  realtime last_rise_t = 0;
  realtime strobe_t    = 0;

  logic [15:0] rx_q[$];   // words the fabric must receive, in order
  logic [15:0] tx_q[$];   // words the master must see on miso, in order

  always @(negedge clk) begin
    if (bus.rx_overrun === 1'b1)  ovr_cnt++;
    if (bus.tx_underrun === 1'b1) udr_cnt++;
  end

  always @(posedge bus.rx_strobe) strobe_t = $realtime;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tx_load(input logic [15:0] w);
    @(negedge clk);
    bus.tx_data   = w;
    bus.tx_strobe = 1'b1;
    @(negedge clk);
    bus.tx_strobe = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk);
    bus.ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    bus.ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Mode-0 master: mosi set while sck low, miso sampled just before each rise.
  task automatic spi_word(input logic [15:0] w, input int nbits, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = w[15-i];
      repeat (HALF) @(negedge clk);
      got = {got[14:0], bus.miso};
      bus.sck = 1'b1;
      last_rise_t = $realtime;
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b0;
    end
  endtask

  task automatic rx_take(input string name);
    int n;
    logic [15:0] data;
    n = 0;
    while (bus.rx_strobe !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rx_wait"}, 32'(n < TMO), 32'd1);
    if (n < TMO) begin
      data = bus.rx_data;
      bus.rx_accept = 1'b1;
      @(negedge clk);
      bus.rx_accept = 1'b0;
      check({name, "_strobe_clr"}, 32'(bus.rx_strobe), 32'd0);
      check({name, "_rx_sb"}, 32'(rx_q.size() != 0), 32'd1);
      if (rx_q.size() != 0) check({name, "_rx_data"}, 32'(data), 32'(rx_q.pop_front()));
    end
  endtask

  task automatic tx_compare(input string name, input logic [15:0] got);
    check({name, "_tx_sb"}, 32'(tx_q.size() != 0), 32'd1);
    if (tx_q.size() != 0) check({name, "_miso"}, 32'(got), 32'(tx_q.pop_front()));
  endtask

  typedef struct {
    logic [15:0] tx_word;
    logic        preload;
    logic [15:0] mosi_word;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [15:0] got3[3];
    logic [15:0] b2b_rx[3];
    logic [15:0] b2b_tx[4];
    int u0, o0;
    realtime lat;

    vecs[0] = '{16'hA55A, 1'b1, 16'h1234};
    vecs[1] = '{16'hDEAD, 1'b0, 16'h5A0F};   // empty holding: miso all zero
    vecs[2] = '{16'hFFFF, 1'b1, 16'h0000};
    vecs[3] = '{16'h8001, 1'b1, 16'h7FFE};
    vecs[4] = '{16'hC3C3, 1'b0, 16'hFFFF};

    bus.ss = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0;
    bus.rx_accept = 1'b0; bus.tx_strobe = 1'b0; bus.tx_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_miso",        32'(bus.miso),        32'd0);
    check("rst_rx_data",     32'(bus.rx_data),     32'd0);
    check("rst_rx_strobe",   32'(bus.rx_strobe),   32'd0);
    check("rst_rx_overrun",  32'(bus.rx_overrun),  32'd0);
    check("rst_tx_request",  32'(bus.tx_request),  32'd1);
    check("rst_tx_underrun", 32'(bus.tx_underrun), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven single-word frames. Holding empties at ss fall, so the
    // word boundary always underruns; ss fall adds one more when not preloaded.
    for (int v = 0; v < 5; v++) begin
      u0 = udr_cnt;
      if (vecs[v].preload) begin
        tx_load(vecs[v].tx_word);
        check("vec_tx_request_low", 32'(bus.tx_request), 32'd0);
        tx_q.push_back(vecs[v].tx_word);
      end else begin
        tx_q.push_back(16'h0000);
      end
      rx_q.push_back(vecs[v].mosi_word);
      frame_start();
      spi_word(vecs[v].mosi_word, 16, got);
      frame_end();
      tx_compare("vec", got);
      rx_take("vec");
      lat = strobe_t - last_rise_t;
      check("vec_strobe_latency", 32'(lat >= SYNC * 10 && lat <= (SYNC + 2) * 10), 32'd1);
      check("vec_underruns", 32'(udr_cnt - u0), vecs[v].preload ? 32'd1 : 32'd2);
    end

    // Back-to-back words with the fabric servicing tx_request and rx_strobe.
    b2b_rx = '{16'hCAFE, 16'h0F0F, 16'h9001};
    b2b_tx = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    tx_load(b2b_tx[0]);
    for (int k = 0; k < 3; k++) begin
      tx_q.push_back(b2b_tx[k]);
      rx_q.push_back(b2b_rx[k]);
    end
    u0 = udr_cnt;
    o0 = ovr_cnt;
    fork
      begin
        frame_start();
        for (int k = 0; k < 3; k++) spi_word(b2b_rx[k], 16, got3[k]);
        frame_end();
      end
      begin
        for (int k = 1; k < 4; k++) begin
          int n;
          n = 0;
          while (bus.tx_request !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
          end
          check("b2b_tx_request_wait", 32'(n < TMO), 32'd1);
          tx_load(b2b_tx[k]);
        end
      end
      begin
        for (int k = 0; k < 3; k++) rx_take("b2b");
      end
    join
    for (int k = 0; k < 3; k++) tx_compare("b2b", got3[k]);
    check("b2b_underruns", 32'(udr_cnt - u0), 32'd0);
    check("b2b_overruns",  32'(ovr_cnt - o0), 32'd0);

    // Two words without rx_accept: second dropped, one overrun pulse,
    // strobe still pending after ss deasserts.
    o0 = ovr_cnt;
    rx_q.push_back(16'h0001);
    frame_start();
    spi_word(16'h0001, 16, got);
    spi_word(16'h0002, 16, got);
    frame_end();
    check("ovr_pulses",    32'(ovr_cnt - o0),  32'd1);
    check("ovr_rx_data",   32'(bus.rx_data),   32'h0001);
    check("ovr_strobe_up", 32'(bus.rx_strobe), 32'd1);
    rx_take("ovr");

    // Partial frame of 7 bits, then a full word.
    tx_load(16'h0F0F);
    frame_start();
    spi_word(16'hFE00, 7, got);
    frame_end();
    check("partial_miso",   32'(got),           32'h0007);
    check("partial_strobe", 32'(bus.rx_strobe), 32'd0);
    tx_load(16'h1357);
    tx_q.push_back(16'h1357);
    rx_q.push_back(16'hBEEF);
    frame_start();
    spi_word(16'hBEEF, 16, got);
    frame_end();
    check("after_partial_strobe", 32'(bus.rx_strobe), 32'd1);
    tx_compare("after_partial", got);
    rx_take("after_partial");

    // Reset asserted after bit 9, with holding refilled and miso high.
    tx_load(16'hFFFF);
    frame_start();
    tx_load(16'h1234);
    spi_word(16'hAAAA, 9, got);
    check("pre_rst_miso",       32'(bus.miso),       32'd1);
    check("pre_rst_tx_request", 32'(bus.tx_request), 32'd0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_miso",       32'(bus.miso),       32'd0);
    check("mid_rst_rx_data",    32'(bus.rx_data),    32'd0);
    check("mid_rst_rx_strobe",  32'(bus.rx_strobe),  32'd0);
    check("mid_rst_tx_request", 32'(bus.tx_request), 32'd1);
    bus.ss = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    tx_load(16'h5AA5);
    tx_q.push_back(16'h5AA5);
    rx_q.push_back(16'h00FF);
    frame_start();
    spi_word(16'h00FF, 16, got);
    frame_end();
    tx_compare("post_rst", got);
    rx_take("post_rst");

    check("rx_sb_drained", 32'(rx_q.size()), 32'd0);
    check("tx_sb_drained", 32'(tx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
